// File: rtl/result_scheduler.sv
// Front-end controller for the face-detection result store: round-robin arbitration of hit
// reports, 3-word record serialisation into the store, and tagged drain of all records to the host.
module result_scheduler #(
  parameter int DATA_WIDTH_12 = 12,
  parameter int NUM_REQ       = 4,
  parameter int MAX_RECORDS   = 1365
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ*DATA_WIDTH_12-1:0] ori_x_bus,
  input  logic [NUM_REQ*DATA_WIDTH_12-1:0] ori_y_bus,
  input  logic [NUM_REQ*DATA_WIDTH_12-1:0] scale_bus,
  output logic [NUM_REQ-1:0]               o_grant,
  output logic                             o_write_in,
  output logic [DATA_WIDTH_12-1:0]         o_data_in,
  input  logic                             drain,
  output logic                             o_read_out,
  input  logic [DATA_WIDTH_12-1:0]         i_data_out,
  output logic                             o_data_valid,
  output logic [DATA_WIDTH_12-1:0]         o_data,
  output logic [1:0]                       o_word_sel,
  output logic                             o_drain_done,
  output logic                             o_full,
  output logic [11:0]                      o_record_count
);

  localparam int              DW      = DATA_WIDTH_12;
  localparam int              IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [11:0]     MAX_CNT = 12'(MAX_RECORDS);

  typedef enum logic [2:0] {IDLE, WRITE, READ, FLUSH, DONE} state_t;

  state_t            state, state_next;
  logic [IDX_W-1:0]  winner, winner_next;
  logic [IDX_W-1:0]  last_grant, last_grant_next;
  logic [1:0]        word_idx, word_idx_next;
  logic [1:0]        rd_tag, rd_tag_next;
  logic [11:0]       record_count, record_count_next;
  logic [12:0]       words_left, words_left_next;
  logic              drain_pending, drain_pending_next;
  logic              rr_found;
  logic [IDX_W-1:0]  rr_idx, rr_cand;

  logic [DW-1:0] x_arr [NUM_REQ];
  logic [DW-1:0] y_arr [NUM_REQ];
  logic [DW-1:0] s_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign x_arr[g] = ori_x_bus[DW*g +: DW];
    assign y_arr[g] = ori_y_bus[DW*g +: DW];
    assign s_arr[g] = scale_bus[DW*g +: DW];
  end

  assign o_full         = (record_count == MAX_CNT);
  assign o_record_count = record_count;

  // Store returns data the cycle after the strobe, which is exactly when o_data_valid is high.
  assign o_data = o_data_valid ? i_data_out : '0;

  // Round-robin: first requester found searching upward from last_grant+1.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    rr_cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      rr_cand = IDX_W'((int'(last_grant) + k) % NUM_REQ);
      if (!rr_found && req[rr_cand]) begin
        rr_found = 1'b1;
        rr_idx   = rr_cand;
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
  always_comb begin
    state_next         = state;
    winner_next        = winner;
    last_grant_next    = last_grant;
    word_idx_next      = word_idx;
    rd_tag_next        = rd_tag;
    record_count_next  = record_count;
    words_left_next    = words_left;
    drain_pending_next = drain_pending;
    o_write_in         = 1'b0;
    o_data_in          = '0;
    o_grant            = '0;
    o_read_out         = 1'b0;
    o_drain_done       = 1'b0;

    case (state)
      IDLE: begin
        if (drain_pending || drain) begin
          drain_pending_next = 1'b0;
          words_left_next    = ({1'b0, record_count} << 1) + {1'b0, record_count};
          rd_tag_next        = 2'd0;
          state_next         = (record_count == '0) ? DONE : READ;
        end else if (rr_found && !o_full) begin
          winner_next   = rr_idx;
          word_idx_next = 2'd0;
          state_next    = WRITE;
        end
      end
      WRITE: begin
        o_write_in = 1'b1;
        case (word_idx)
          2'd0:    o_data_in = x_arr[winner];
          2'd1:    o_data_in = y_arr[winner];
          default: o_data_in = s_arr[winner];
        endcase
        if (word_idx == 2'd2) begin
          o_grant[winner]   = 1'b1;
          record_count_next = record_count + 12'd1;
          last_grant_next   = winner;
          state_next        = IDLE;
        end else begin
          word_idx_next = word_idx + 2'd1;
        end
      end
      READ: begin
        o_read_out      = 1'b1;
        words_left_next = words_left - 13'd1;
        rd_tag_next     = (rd_tag == 2'd2) ? 2'd0 : rd_tag + 2'd1;
        if (words_left == 13'd1) state_next = FLUSH;
      end
      FLUSH: state_next = DONE;
      DONE: begin
        o_drain_done      = 1'b1;
        record_count_next = '0;
        state_next        = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // A drain seen mid-record waits for the record; one seen mid-drain is absorbed by it.
    if (drain && (state == WRITE || state == DONE)) drain_pending_next = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      winner        <= '0;
      last_grant    <= IDX_W'(NUM_REQ - 1);
      word_idx      <= '0;
      rd_tag        <= '0;
      record_count  <= '0;
      words_left    <= '0;
      drain_pending <= 1'b0;
      o_data_valid  <= 1'b0;
      o_word_sel    <= '0;
    end else begin
      state         <= state_next;
      winner        <= winner_next;
      last_grant    <= last_grant_next;
      word_idx      <= word_idx_next;
      rd_tag        <= rd_tag_next;
      record_count  <= record_count_next;
      words_left    <= words_left_next;
      drain_pending <= drain_pending_next;
      o_data_valid  <= o_read_out;
      o_word_sel    <= o_read_out ? rd_tag : 2'd0;
    end
  end

endmodule

// File: tb/tb_result_scheduler.sv
// Directed bench for result_scheduler with a behavioural result store and scoreboard queues
// for store writes, grants and host words.
module tb_result_scheduler;

  localparam int NR   = 4;
  localparam int DW   = 12;
  localparam int MAXR = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req;
  logic [NR*DW-1:0]  ori_x_bus, ori_y_bus, scale_bus;
  logic [NR-1:0]     o_grant;
  logic              o_write_in;
  logic [DW-1:0]     o_data_in;
  logic              drain;
  logic              o_read_out;
  logic [DW-1:0]     i_data_out = '0;
  logic              o_data_valid;
  logic [DW-1:0]     o_data;
  logic [1:0]        o_word_sel;
  logic              o_drain_done;
  logic              o_full;
  logic [11:0]       o_record_count;

  result_scheduler #(.DATA_WIDTH_12(DW), .NUM_REQ(NR), .MAX_RECORDS(MAXR)) dut (
    .clk(clk), .reset(rst_n), .req(req),
    .ori_x_bus(ori_x_bus), .ori_y_bus(ori_y_bus), .scale_bus(scale_bus),
    .o_grant(o_grant), .o_write_in(o_write_in), .o_data_in(o_data_in),
    .drain(drain), .o_read_out(o_read_out), .i_data_out(i_data_out),
    .o_data_valid(o_data_valid), .o_data(o_data), .o_word_sel(o_word_sel),
    .o_drain_done(o_drain_done), .o_full(o_full), .o_record_count(o_record_count)
  );

  always #5 clk = ~clk;

  // Behavioural store: FIFO with one-cycle registered read, reset alongside the DUT.
  logic [DW-1:0] store_q[$];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      store_q.delete();
      i_data_out <= '0;
    end else begin
      if (o_write_in) store_q.push_back(o_data_in);
      if (o_read_out && store_q.size() > 0) i_data_out <= store_q.pop_front();
    end
  end

  int n_checks = 0;
  int n_err    = 0;
  int grants_seen = 0;
  int dones_seen  = 0;

  logic [DW-1:0]   wr_q[$];
  logic [NR-1:0]   grant_q[$];
  logic [DW+1:0]   rd_q[$];
  logic [3*DW-1:0] model_q[$];
  logic [DW-1:0]   cur_x [NR];
  logic [DW-1:0]   cur_y [NR];
  logic [DW-1:0]   cur_s [NR];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    if (o_write_in && o_read_out) check("write_read_overlap", 32'(1), 32'(0));
    if (o_write_in) begin
      if (wr_q.size() == 0) check("write_unexpected", 32'(o_data_in), 32'hFFFF_FFFF);
      else check("write_data", 32'(o_data_in), 32'(wr_q.pop_front()));
    end
    if (o_grant != '0) begin
      grants_seen++;
      if (grant_q.size() == 0) check("grant_unexpected", 32'(o_grant), 32'(0));
      else check("grant", 32'(o_grant), 32'(grant_q.pop_front()));
    end
    if (o_data_valid) begin
      if (rd_q.size() == 0) check("valid_unexpected", 32'({o_word_sel, o_data}), 32'hFFFF_FFFF);
      else check("host_word", 32'({o_word_sel, o_data}), 32'(rd_q.pop_front()));
    end
    if (o_drain_done) dones_seen++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    monitor();
  endtask

  task automatic set_data(input int i, input logic [DW-1:0] x, input logic [DW-1:0] y,
                          input logic [DW-1:0] s);
    cur_x[i] = x; cur_y[i] = y; cur_s[i] = s;
    ori_x_bus[DW*i +: DW] = x;
    ori_y_bus[DW*i +: DW] = y;
    scale_bus[DW*i +: DW] = s;
  endtask

  task automatic expect_record(input int i);
    wr_q.push_back(cur_x[i]);
    wr_q.push_back(cur_y[i]);
    wr_q.push_back(cur_s[i]);
    grant_q.push_back(NR'(1) << i);
    model_q.push_back({cur_x[i], cur_y[i], cur_s[i]});
  endtask

  task automatic expect_drain();
    logic [3*DW-1:0] r;
    while (model_q.size() > 0) begin
      r = model_q.pop_front();
      rd_q.push_back({2'd0, r[3*DW-1:2*DW]});
      rd_q.push_back({2'd1, r[2*DW-1:DW]});
      rd_q.push_back({2'd2, r[DW-1:0]});
    end
  endtask

  task automatic wait_grants(input int n, input int budget);
    int target;
    int k;
    target = grants_seen + n;
    k = 0;
    while (grants_seen < target && k < budget) begin
      tick();
      k++;
    end
    if (grants_seen < target) check("grant_timeout", 32'(grants_seen), 32'(target));
  endtask

  task automatic wait_done(input int budget);
    int target;
    int k;
    target = dones_seen + 1;
    k = 0;
    while (dones_seen < target && k < budget) begin
      tick();
      k++;
    end
    if (dones_seen < target) check("done_timeout", 32'(dones_seen), 32'(target));
  endtask

  task automatic check_outputs_zero(input string pfx);
    check({pfx, "_grant"},    32'(o_grant),        32'(0));
    check({pfx, "_write_in"}, 32'(o_write_in),     32'(0));
    check({pfx, "_data_in"},  32'(o_data_in),      32'(0));
    check({pfx, "_read_out"}, 32'(o_read_out),     32'(0));
    check({pfx, "_valid"},    32'(o_data_valid),   32'(0));
    check({pfx, "_data"},     32'(o_data),         32'(0));
    check({pfx, "_word_sel"}, 32'(o_word_sel),     32'(0));
    check({pfx, "_done"},     32'(o_drain_done),   32'(0));
    check({pfx, "_full"},     32'(o_full),         32'(0));
    check({pfx, "_count"},    32'(o_record_count), 32'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd_cnt, vld_cnt, done_at, dones0;
    rst_n = 1'b0; req = '0; drain = 1'b0;
    ori_x_bus = '0; ori_y_bus = '0; scale_bus = '0;
    for (int i = 0; i < NR; i++) set_data(i, DW'(16*i + 1), DW'(16*i + 2), DW'(16*i + 3));

    repeat (2) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst_n = 1'b1;
    tick();

    // Round-robin with all four requesters held; capacity 2 forces hold-off and drains.
    expect_record(0);
    expect_record(1);
    req = 4'hF;
    wait_grants(2, 20);
    repeat (8) tick();
    check("full_flag", 32'(o_full), 32'(1));
    check("full_count", 32'(o_record_count), 32'(2));
    expect_drain();
    drain = 1'b1;
    tick();
    drain = 1'b0;
    wait_done(30);
    expect_record(2);
    expect_record(3);
    wait_grants(2, 20);
    repeat (4) tick();
    expect_drain();
    drain = 1'b1;
    tick();
    drain = 1'b0;
    wait_done(30);
    expect_record(0);
    wait_grants(1, 20);
    tick();
    req = '0;
    check("rr_count", 32'(o_record_count), 32'(1));

    // One-record drain: strobes T+1..T+3, done at T+5.
    expect_drain();
    drain = 1'b1;
    rd_cnt = 0; done_at = 0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      drain = 1'b0;
      if (o_read_out) rd_cnt++;
      if (o_drain_done) done_at = k;
    end
    check("drain1_reads", 32'(rd_cnt), 32'(3));
    check("drain1_done_at", 32'(done_at), 32'(5));
    check("drain1_count", 32'(o_record_count), 32'(0));

    // Empty drain: done the next cycle, no strobes.
    drain = 1'b1;
    rd_cnt = 0; done_at = 0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      drain = 1'b0;
      if (o_read_out) rd_cnt++;
      if (o_drain_done) done_at = k;
    end
    check("empty_reads", 32'(rd_cnt), 32'(0));
    check("empty_done_at", 32'(done_at), 32'(1));

    // Single hit on requester 2 with exact write latency.
    set_data(2, 12'd100, 12'd200, 12'd3);
    expect_record(2);
    req = 4'b0100;
    tick();
    check("hit_write_t1", 32'(o_write_in), 32'(1));
    tick();
    tick();
    check("hit_grant_t3", 32'(o_grant), 32'(4'b0100));
    tick();
    req = '0;
    check("hit_idle_t4", 32'(o_write_in), 32'(0));
    check("hit_count", 32'(o_record_count), 32'(1));

    // Second record, then a two-record drain with a redundant drain pulse mid-read.
    set_data(1, 12'd7, 12'd8, 12'd9);
    expect_record(1);
    req = 4'b0010;
    wait_grants(1, 10);
    tick();
    req = '0;
    check("two_full", 32'(o_full), 32'(1));
    expect_drain();
    drain = 1'b1;
    rd_cnt = 0; vld_cnt = 0; done_at = 0; dones0 = dones_seen;
    for (int k = 1; k <= 10; k++) begin
      tick();
      drain = (k == 3);
      if (o_read_out) rd_cnt++;
      if (o_data_valid) vld_cnt++;
      if (o_drain_done) done_at = k;
    end
    drain = 1'b0;
    check("drain2_reads", 32'(rd_cnt), 32'(6));
    check("drain2_valid", 32'(vld_cnt), 32'(6));
    check("drain2_done_at", 32'(done_at), 32'(8));
    check("drain2_single_done", 32'(dones_seen - dones0), 32'(1));
    check("drain2_count", 32'(o_record_count), 32'(0));
    check("drain2_not_full", 32'(o_full), 32'(0));

    // Drain raised at word 1 of a record: record completes, then it is drained.
    set_data(3, 12'hABC, 12'h123, 12'h7FF);
    expect_record(3);
    req = 4'b1000;
    tick();
    tick();
    drain = 1'b1;
    expect_drain();
    tick();
    drain = 1'b0;
    check("dw_write_t3", 32'(o_write_in), 32'(1));
    check("dw_grant_t3", 32'(o_grant), 32'(4'b1000));
    done_at = 0;
    for (int k = 4; k <= 12; k++) begin
      tick();
      req = '0;
      if (o_drain_done) done_at = k;
    end
    check("dw_done_at", 32'(done_at), 32'(9));
    check("dw_count", 32'(o_record_count), 32'(0));

    // Asynchronous reset two cycles into a drain.
    set_data(0, 12'h111, 12'h222, 12'h333);
    expect_record(0);
    req = 4'b0001;
    wait_grants(1, 10);
    tick();
    req = '0;
    expect_drain();
    drain = 1'b1;
    tick();
    drain = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("rst_read");
    wr_q.delete(); grant_q.delete(); rd_q.delete(); model_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    dones0 = dones_seen;
    repeat (4) tick();
    check("rst_no_done", 32'(dones_seen - dones0), 32'(0));
    check("rst_no_read", 32'(o_read_out), 32'(0));
    drain = 1'b1;
    tick();
    drain = 1'b0;
    check("rst_idle_empty_drain", 32'(o_drain_done), 32'(1));
    tick();

    check("wr_q_drained", 32'(wr_q.size()), 32'(0));
    check("grant_q_drained", 32'(grant_q.size()), 32'(0));
    check("rd_q_drained", 32'(rd_q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
